// File: rtl/miriscv_mdu_pkg.sv
// Opcode encodings and FSM state type shared by the multiply/divide unit.
// Optional macro MIRISCV_MDU_FAST_MUL_EN (used in the top) selects a single-cycle multiplier.
package miriscv_mdu_pkg;

   localparam int MDU_OP_WIDTH = 3;

   localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } mdu_state_e;

endpackage

// File: rtl/miriscv_mdu_div_iter.sv
// Restoring-divide datapath on unsigned magnitudes: one quotient bit per step.
// o_quo_next/o_rem_next show the values the current step would produce.
module miriscv_mdu_div_iter
   import miriscv_mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            i_load,
   input  logic            i_step,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_quo_next,
   output logic [XLEN-1:0] o_rem_next
);

   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_div;

   logic [XLEN:0]   w_diff;
   logic            w_fits;

   // The dividend shifts out of r_quo MSB-first while quotient bits shift in at the bottom.
   assign w_diff     = {r_rem, r_quo[XLEN-1]} - {1'b0, r_div};
   assign w_fits     = ~w_diff[XLEN];
   assign o_rem_next = w_fits ? w_diff[XLEN-1:0] : {r_rem[XLEN-2:0], r_quo[XLEN-1]};
   assign o_quo_next = {r_quo[XLEN-2:0], w_fits};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rem <= '0;
         r_quo <= '0;
         r_div <= '0;
      end else if (i_load) begin
         r_rem <= '0;
         r_quo <= i_dividend;
         r_div <= i_divisor;
      end else if (i_step) begin
         r_rem <= o_rem_next;
         r_quo <= o_quo_next;
      end
   end

endmodule

// File: rtl/miriscv_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready request and one-cycle result pulse.
// Define MIRISCV_MDU_FAST_MUL_EN to replace the shift-add multiply with a single-cycle array multiply.
module miriscv_mdu
   import miriscv_mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    mdu_req_i,
   input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
   input  logic [XLEN-1:0]         mdu_port_a_i,
   input  logic [XLEN-1:0]         mdu_port_b_i,
   input  logic                    mdu_kill_i,
   output logic                    mdu_ready_o,
   output logic                    mdu_valid_o,
   output logic [XLEN-1:0]         mdu_result_o
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   mdu_state_e              r_state;
   logic [MDU_OP_WIDTH-1:0] r_op;
   logic [XLEN-1:0]         r_a;
   logic [2*XLEN-1:0]       r_prod;
   logic                    r_neg;
   logic                    r_rem_neg;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_valid;
   logic [XLEN-1:0]         r_result;

   logic                    w_accept;
   logic                    w_is_div;
   logic                    w_a_signed;
   logic                    w_b_signed;
   logic                    w_a_neg;
   logic                    w_b_neg;
   logic [XLEN-1:0]         w_a_mag;
   logic [XLEN-1:0]         w_b_mag;
   logic                    w_div_zero;
   logic                    w_div_ovf;
   logic [XLEN-1:0]         w_special_res;

   logic [XLEN:0]           w_mul_sum;
   logic [2*XLEN-1:0]       w_prod_next;
   logic [2*XLEN-1:0]       w_prod_fix;
   logic [XLEN-1:0]         w_mul_res;

   logic [XLEN-1:0]         w_quo_next;
   logic [XLEN-1:0]         w_rem_next;
   logic [XLEN-1:0]         w_quo_fix;
   logic [XLEN-1:0]         w_rem_fix;
   logic [XLEN-1:0]         w_div_res;

   assign w_accept   = mdu_req_i & (r_state == IDLE);
   assign w_is_div   = mdu_op_i[2];
   assign w_a_signed = (mdu_op_i == MDU_MULH) | (mdu_op_i == MDU_MULHSU) |
                       (mdu_op_i == MDU_DIV)  | (mdu_op_i == MDU_REM);
   assign w_b_signed = (mdu_op_i == MDU_MULH) | (mdu_op_i == MDU_DIV) | (mdu_op_i == MDU_REM);
   assign w_a_neg    = w_a_signed & mdu_port_a_i[XLEN-1];
   assign w_b_neg    = w_b_signed & mdu_port_b_i[XLEN-1];
   assign w_a_mag    = w_a_neg ? -mdu_port_a_i : mdu_port_a_i;
   assign w_b_mag    = w_b_neg ? -mdu_port_b_i : mdu_port_b_i;

   // Divide-by-zero and signed overflow have fixed answers and skip the iteration entirely.
   assign w_div_zero    = w_is_div & (mdu_port_b_i == '0);
   assign w_div_ovf     = ((mdu_op_i == MDU_DIV) | (mdu_op_i == MDU_REM)) &
                          (mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (mdu_port_b_i == '1);
   assign w_special_res = w_div_zero ? (mdu_op_i[1] ? mdu_port_a_i : '1)
                                     : (mdu_op_i[1] ? '0 : mdu_port_a_i);

   // Shift-add step: r_prod holds {partial sum, remaining multiplier bits}.
   assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
   assign w_prod_next = {w_mul_sum, r_prod[XLEN-1:1]};
   assign w_prod_fix  = r_neg ? -w_prod_next : w_prod_next;
   assign w_mul_res   = (r_op == MDU_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];

   miriscv_mdu_div_iter #(
      .XLEN(XLEN)
   ) u_div_iter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_load     (w_accept),
      .i_step     ((r_state == DIV) & ~mdu_kill_i),
      .i_dividend (w_a_mag),
      .i_divisor  (w_b_mag),
      .o_quo_next (w_quo_next),
      .o_rem_next (w_rem_next)
   );

   assign w_quo_fix = r_neg ? -w_quo_next : w_quo_next;
   assign w_rem_fix = r_rem_neg ? -w_rem_next : w_rem_next;
   assign w_div_res = r_op[1] ? w_rem_fix : w_quo_fix;

`ifdef MIRISCV_MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] w_fast_prod;
   logic [2*XLEN-1:0] w_fast_fix;
   logic [XLEN-1:0]   w_fast_res;

   assign w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
   assign w_fast_fix  = (w_a_neg ^ w_b_neg) ? -w_fast_prod : w_fast_prod;
   assign w_fast_res  = (mdu_op_i == MDU_MUL) ? w_fast_fix[XLEN-1:0] : w_fast_fix[2*XLEN-1:XLEN];
`endif

   // Control FSM; the last iteration step lands directly in r_result on the way into DONE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_op      <= '0;
         r_a       <= '0;
         r_prod    <= '0;
         r_neg     <= 1'b0;
         r_rem_neg <= 1'b0;
         r_cnt     <= '0;
         r_valid   <= 1'b0;
         r_result  <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (mdu_req_i) begin
                  r_op      <= mdu_op_i;
                  r_a       <= w_a_mag;
                  r_prod    <= {{XLEN{1'b0}}, w_b_mag};
                  r_neg     <= w_a_neg ^ w_b_neg;
                  r_rem_neg <= w_a_neg;
                  r_cnt     <= CNT_W'(XLEN);
                  if (w_div_zero | w_div_ovf) begin
                     r_result <= w_special_res;
                     r_valid  <= 1'b1;
                     r_state  <= DONE;
                  end else if (w_is_div) begin
                     r_state <= DIV;
`ifdef MIRISCV_MDU_FAST_MUL_EN
                  end else begin
                     r_result <= w_fast_res;
                     r_valid  <= 1'b1;
                     r_state  <= DONE;
                  end
`else
                  end else begin
                     r_state <= MUL;
                  end
`endif
               end
            end
            MUL: begin
               if (mdu_kill_i) begin
                  r_state <= IDLE;
               end else begin
                  r_prod <= w_prod_next;
                  r_cnt  <= r_cnt - CNT_W'(1);
                  if (r_cnt == CNT_W'(1)) begin
                     r_result <= w_mul_res;
                     r_valid  <= 1'b1;
                     r_state  <= DONE;
                  end
               end
            end
            DIV: begin
               if (mdu_kill_i) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_cnt == CNT_W'(1)) begin
                     r_result <= w_div_res;
                     r_valid  <= 1'b1;
                     r_state  <= DONE;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign mdu_ready_o  = (r_state == IDLE);
   assign mdu_valid_o  = r_valid;
   assign mdu_result_o = r_result;

endmodule

// File: tb/tb_miriscv_mdu.sv
// Self-checking bench for miriscv_mdu: arithmetic reference model plus per-cycle compare.
// Honours MIRISCV_MDU_FAST_MUL_EN for the expected multiply latency.
module tb_miriscv_mdu;
   import miriscv_mdu_pkg::*;

   localparam int XLEN = 32;
`ifdef MIRISCV_MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = XLEN + 1;
`endif

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        req    = 1'b0;
   logic        kill   = 1'b0;
   logic [2:0]  opIn   = '0;
   logic [31:0] aIn    = '0;
   logic [31:0] bIn    = '0;
   logic        ready;
   logic        valid;
   logic [31:0] result;

   int          tests      = 0;
   int          fails      = 0;
   int          edgeCnt    = 0;
   int          doneEdge   = 0;
   int          acceptEdge = 0;
   bit          busy       = 1'b0;
   bit          checkEn    = 1'b0;
   logic [31:0] pendRes    = '0;
   logic [31:0] heldRes    = '0;
   logic [31:0] edgeVals [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

   always #5 clk = ~clk;

   miriscv_mdu #(
      .XLEN(XLEN)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .mdu_req_i    (req),
      .mdu_op_i     (opIn),
      .mdu_port_a_i (aIn),
      .mdu_port_b_i (bIn),
      .mdu_kill_i   (kill),
      .mdu_ready_o  (ready),
      .mdu_valid_o  (valid),
      .mdu_result_o (result)
   );

   // Architectural RV32M result, straight from the ISA definitions.
   function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int          sa;
      int          sb;
      bit          ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
      case (op)
         MDU_MUL:    begin p = {32'd0, a} * {32'd0, b};               return p[31:0];  end
         MDU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   return p[63:32]; end
         MDU_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b};         return p[63:32]; end
         MDU_MULHU:  begin p = {32'd0, a} * {32'd0, b};               return p[63:32]; end
         MDU_DIV:    return (b == 0) ? 32'hFFFFFFFF : (ovf ? a : 32'(sa / sb));
         MDU_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
         MDU_REM:    return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
         default:    return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 0) return 1;
      if ((op == MDU_DIV || op == MDU_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      if (op[2]) return XLEN + 1;
      return MUL_LAT;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edgeCnt);
      end
   endtask

   // Transaction-level model: tracks accept/kill/reset and when the result is due.
   always @(posedge clk) begin
      edgeCnt++;
      if (rst) begin
         busy    = 1'b0;
         heldRes = '0;
      end else begin
         if (busy && (kill || edgeCnt == doneEdge)) begin
            busy = 1'b0;
         end else if (!busy && req) begin
            busy     = 1'b1;
            pendRes  = refResult(opIn, aIn, bIn);
            doneEdge = edgeCnt + refLatency(opIn, aIn, bIn);
         end
         if (busy && edgeCnt == doneEdge - 1) heldRes = pendRes;
      end
   end

   always @(negedge clk) begin
      if (checkEn) begin
         check("ready", ready, !busy);
         check("valid", valid, busy && (edgeCnt == doneEdge - 1));
         check("result", result, heldRes);
      end
   end

   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit withKill);
      int guard = 0;
      while (busy && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (busy) begin
         tests++;
         fails++;
         $display("[TB] FAIL idle_wait: unit still busy after %0d cycles", guard);
      end
      opIn       = op;
      aIn        = a;
      bIn        = b;
      req        = 1'b1;
      kill       = withKill;
      acceptEdge = edgeCnt + 1;
      @(posedge clk);
      #1;
      req  = 1'b0;
      kill = 1'b0;
      opIn = 3'($urandom);
      aIn  = $urandom;
      bIn  = $urandom;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] expRes, input int expLat);
      int waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!valid && waited < 100);
      if (!valid) begin
         tests++;
         fails++;
         $display("[TB] FAIL %s_timeout: no valid pulse within %0d cycles", name, waited);
      end else begin
         check({name, "_res"}, result, expRes);
         check({name, "_lat"}, edgeCnt - acceptEdge + 1, expLat);
      end
   endtask

   initial begin
      int nValid;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;

      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      checkEn = 1'b1;

      applyStimulus(MDU_MUL, 32'd7, 32'hFFFFFFFD, 1'b0);
      checkOutput("mul_7xm3", 32'hFFFFFFEB, MUL_LAT);
      applyStimulus(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      checkOutput("mulhu_ones", 32'hFFFFFFFE, MUL_LAT);
      applyStimulus(MDU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      checkOutput("mulh_ones", 32'h00000000, MUL_LAT);
      applyStimulus(MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      checkOutput("mulhsu_ones", 32'hFFFFFFFF, MUL_LAT);
      applyStimulus(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
      checkOutput("div_m7_2", 32'hFFFFFFFD, XLEN + 1);
      applyStimulus(MDU_REM, 32'hFFFFFFF9, 32'd2, 1'b0);
      checkOutput("rem_m7_2", 32'hFFFFFFFF, XLEN + 1);
      applyStimulus(MDU_DIVU, 32'd100, 32'd7, 1'b1);
      checkOutput("divu_100_7_killreq", 32'd14, XLEN + 1);
      applyStimulus(MDU_REMU, 32'd100, 32'd7, 1'b0);
      checkOutput("remu_100_7", 32'd2, XLEN + 1);
      applyStimulus(MDU_DIVU, 32'd5, 32'd0, 1'b0);
      checkOutput("divu_by0", 32'hFFFFFFFF, 1);
      applyStimulus(MDU_REMU, 32'd5, 32'd0, 1'b0);
      checkOutput("remu_by0", 32'd5, 1);
      applyStimulus(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      checkOutput("div_ovf", 32'h80000000, 1);
      applyStimulus(MDU_REM, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      checkOutput("rem_ovf", 32'h0, 1);

      // Kill ten cycles into a divide, then a clean multiply.
      applyStimulus(MDU_DIV, 32'd1000, 32'd3, 1'b0);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      @(negedge clk);
      check("kill_ready", ready, 1'b1);
      check("kill_valid", valid, 1'b0);
      nValid = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) nValid++;
      end
      check("kill_no_pulse", nValid, 0);
      applyStimulus(MDU_MUL, 32'd3, 32'd4, 1'b0);
      checkOutput("mul_3x4", 32'd12, MUL_LAT);

      // Reset in the middle of a multiply.
      applyStimulus(MDU_MUL, 32'h00012345, 32'h00000777, 1'b0);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", ready, 1'b1);
      check("rst_valid", valid, 1'b0);
      check("rst_result", result, 32'h0);
      nValid = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid) nValid++;
      end
      check("rst_no_pulse", nValid, 0);

      // Randomized traffic with occasional kills at arbitrary points.
      for (int n = 0; n < 250; n++) begin
         op = 3'($urandom);
         case ($urandom_range(0, 4))
            0: begin a = $urandom; b = $urandom; end
            1: begin a = $urandom_range(0, 255); b = $urandom_range(0, 15); end
            2: begin a = $urandom; b = 32'h0; end
            3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            default: begin a = edgeVals[$urandom_range(0, 4)]; b = edgeVals[$urandom_range(0, 4)]; end
         endcase
         applyStimulus(op, a, b, ($urandom_range(0, 9) == 0));
         for (int i = 0; i < int'($urandom_range(0, 45)); i++) begin
            kill = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            #1;
         end
         kill = 1'b0;
      end
      repeat (XLEN + 4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
